// File: rtl/bus_ctrl_3m2t_pkg.sv
// Shared constants for the 3-master / 2-target bus interconnect:
// bus word widths, request/response field positions, master ids.
package bus_ctrl_3m2t_pkg;

    localparam int REQ_W     = 70;  // {addr[69:38], rd[37], wr[36], wd[35:4], be[3:0]}
    localparam int RES_W     = 34;  // {wait[33], rd_valid[32], rd_data[31:0]}
    localparam int NUM_M     = 3;
    localparam int NUM_T     = 2;

    localparam int RQ_RD      = 37;
    localparam int RQ_WR      = 36;
    localparam int RQ_TGT_MSB = 69; // addr[31:24]
    localparam int RQ_TGT_LSB = 62;

    localparam int RS_WAIT   = 33;
    localparam int RS_VLD    = 32;
    localparam int RS_DATA_W = 32;

    typedef logic [1:0] mid_t;
    localparam mid_t MID_M1 = 2'd0;
    localparam mid_t MID_M2 = 2'd1;
    localparam mid_t MID_M3 = 2'd2;

    // Response driven to every master while reset is asserted
    localparam logic [RES_W-1:0] RES_RST = 34'h2_0000_0000;

    // 1 when the request addresses target 2, 0 for target 1
    function automatic logic dec_t2(input logic [REQ_W-1:0] req, input logic [7:0] base);
        return req[RQ_TGT_MSB:RQ_TGT_LSB] == base;
    endfunction

endpackage

// File: rtl/bus_ctrl_3m2t_if.sv
// One pipelined bus link: request from the initiator, response back.
// master = initiator side, slave = responder side.
interface bus_ctrl_3m2t_if;
    import bus_ctrl_3m2t_pkg::*;

    logic [REQ_W-1:0] req;
    logic [RES_W-1:0] res;

    modport master (output req, input res);
    modport slave  (input req, output res);
endinterface

// File: rtl/bus_ctrl_3m2t_tag_fifo.sv
// Tag FIFO holding the master id of each read accepted by one target,
// in issue order. Pop with empty is ignored.
module bus_tag_fifo
    import bus_ctrl_3m2t_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk25MHz,
    input  logic reset_n,
    input  logic i_push,
    input  logic i_pop,
    input  mid_t i_id,
    output logic o_full,
    output logic o_empty,
    output mid_t o_head
);
    localparam int AW = $clog2(DEPTH);

    mid_t [DEPTH-1:0] r_mem;
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [AW:0]      r_cnt;
    logic             w_push;
    logic             w_pop;

    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);
    assign o_full  = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_head  = r_mem[r_rp];

    // Storage needs no reset: entries are only read when the count says valid
    always_ff @(posedge clk25MHz) begin
        if (w_push) r_mem[r_wp] <= i_id;
    end

    // Pointers wrap naturally (DEPTH is a power of 2); push+pop keeps the count
    always_ff @(posedge clk25MHz) begin
        if (!reset_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
            else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/bus_ctrl_3m2t.sv
// Interconnect: 3 pipelined masters (m1 VGA, m2 I-mem, m3 D-mem) to
// 2 targets (t1 SRAM, t2 peripherals, selected by addr[31:24]==T2_BASE).
// Combinational per-target grant, in-order read return via tag FIFOs.
// Optional macro BUS_CTRL_RR_EN: m2/m3 round-robin per target (m1 still
// absolute priority); otherwise fixed priority m1>m2>m3.
module bus_ctrl_3m2t
    import bus_ctrl_3m2t_pkg::*;
#(
    parameter int         TAG_DEPTH = 4,
    parameter logic [7:0] T2_BASE   = 8'hFF
) (
    input  logic           clk25MHz,
    input  logic           reset_n,
    bus_ctrl_3m2t_if.slave  m1,
    bus_ctrl_3m2t_if.slave  m2,
    bus_ctrl_3m2t_if.slave  m3,
    bus_ctrl_3m2t_if.master t1,
    bus_ctrl_3m2t_if.master t2
);

    logic [NUM_M-1:0][REQ_W-1:0] w_mreq;
    logic [NUM_M-1:0][RES_W-1:0] w_mres;
    logic [NUM_T-1:0][REQ_W-1:0] w_treq;
    logic [NUM_T-1:0][RES_W-1:0] w_tres;

    logic [NUM_M-1:0]            w_rd;
    logic [NUM_M-1:0]            w_wr;
    logic [NUM_M-1:0]            w_tsel;   // 1 = target 2
    logic [NUM_M-1:0]            w_elig;
    logic [NUM_T-1:0][NUM_M-1:0] w_cand;
    logic [NUM_T-1:0]            w_gnt_vld;
    mid_t [NUM_T-1:0]            w_gnt_id;
    logic [NUM_T-1:0]            w_tack;   // winner's transfer completes
    logic [NUM_T-1:0]            w_push;
    logic [NUM_T-1:0]            w_pop;
    logic [NUM_T-1:0]            w_full;
    logic [NUM_T-1:0]            w_empty;
    mid_t [NUM_T-1:0]            w_head;
    logic [NUM_M-1:0]            w_inc;
    logic [NUM_M-1:0]            w_dec;
    logic [NUM_M-1:0]            w_inc_t2;

    // Reads outstanding per master, and which target holds them. A master only
    // ever has reads at one target, so one flag per master is enough.
    logic [NUM_M-1:0][2:0]       r_cnt;
    logic [NUM_M-1:0]            r_ot_t2;

`ifdef BUS_CTRL_RR_EN
    logic [NUM_T-1:0]            r_rr_m3;  // 1 = m3 wins the next m2/m3 tie
`endif

    assign w_mreq[0] = m1.req;
    assign w_mreq[1] = m2.req;
    assign w_mreq[2] = m3.req;
    assign m1.res    = w_mres[0];
    assign m2.res    = w_mres[1];
    assign m3.res    = w_mres[2];
    assign t1.req    = w_treq[0];
    assign t2.req    = w_treq[1];
    assign w_tres[0] = t1.res;
    assign w_tres[1] = t2.res;

    // Decode and eligibility: reads need tag room and no reads pending elsewhere
    always_comb begin
        w_rd   = '0;
        w_wr   = '0;
        w_tsel = '0;
        w_elig = '0;
        for (int m = 0; m < NUM_M; m++) begin
            w_rd[m]   = w_mreq[m][RQ_RD];
            w_wr[m]   = w_mreq[m][RQ_WR];
            w_tsel[m] = dec_t2(w_mreq[m], T2_BASE);
            w_elig[m] = w_wr[m] |
                        (w_rd[m] & ~w_full[w_tsel[m]] &
                         ((r_cnt[m] == 3'd0) | (r_ot_t2[m] == w_tsel[m])));
        end
    end

    // Per-target candidates and priority grant
    always_comb begin
        w_cand    = '0;
        w_gnt_vld = '0;
        w_gnt_id  = '0;
        for (int k = 0; k < NUM_T; k++) begin
            for (int m = 0; m < NUM_M; m++)
                w_cand[k][m] = w_elig[m] && (int'(w_tsel[m]) == k);
            w_gnt_vld[k] = |w_cand[k];
            if (w_cand[k][0])                        w_gnt_id[k] = MID_M1;
`ifdef BUS_CTRL_RR_EN
            else if (w_cand[k][1] && w_cand[k][2])   w_gnt_id[k] = r_rr_m3[k] ? MID_M3 : MID_M2;
`endif
            else if (w_cand[k][1])                   w_gnt_id[k] = MID_M2;
            else if (w_cand[k][2])                   w_gnt_id[k] = MID_M3;
        end
    end

    // Forward the winner, tag accepted reads, pop tags on returned data
    always_comb begin
        w_treq = '0;
        w_tack = '0;
        w_push = '0;
        w_pop  = '0;
        for (int k = 0; k < NUM_T; k++) begin
            if (reset_n && w_gnt_vld[k]) begin
                w_treq[k] = w_mreq[w_gnt_id[k]];
                w_tack[k] = ~w_tres[k][RS_WAIT];
                w_push[k] = w_tack[k] & w_rd[w_gnt_id[k]];
            end
            w_pop[k] = reset_n & w_tres[k][RS_VLD] & ~w_empty[k];
        end
    end

    // Master responses and counter events; losing requesters stall
    always_comb begin
        w_mres   = '0;
        w_inc    = '0;
        w_dec    = '0;
        w_inc_t2 = '0;
        for (int m = 0; m < NUM_M; m++) begin
            w_mres[m][RS_WAIT] = w_rd[m] | w_wr[m];
            for (int k = 0; k < NUM_T; k++) begin
                if (w_gnt_vld[k] && w_gnt_id[k] == mid_t'(m))
                    w_mres[m][RS_WAIT] = w_tres[k][RS_WAIT];
                if (w_push[k] && w_gnt_id[k] == mid_t'(m)) begin
                    w_inc[m]    = 1'b1;
                    w_inc_t2[m] = (k == 1);
                end
                if (w_pop[k] && w_head[k] == mid_t'(m)) begin
                    w_dec[m]                    = 1'b1;
                    w_mres[m][RS_VLD]           = 1'b1;
                    w_mres[m][RS_DATA_W-1:0]   |= w_tres[k][RS_DATA_W-1:0];
                end
            end
            if (!reset_n) w_mres[m] = RES_RST;
        end
    end

    // Outstanding-read counters and the target they belong to
    always_ff @(posedge clk25MHz) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_ot_t2 <= '0;
        end else begin
            for (int m = 0; m < NUM_M; m++) begin
                if (w_inc[m] && !w_dec[m])      r_cnt[m] <= r_cnt[m] + 3'd1;
                else if (!w_inc[m] && w_dec[m]) r_cnt[m] <= r_cnt[m] - 3'd1;
                if (w_inc[m]) r_ot_t2[m] <= w_inc_t2[m];
            end
        end
    end

`ifdef BUS_CTRL_RR_EN
    // Flip the m2/m3 preference after any completed m2 or m3 transfer
    // (writes included, so a writing m2 cannot starve m3)
    always_ff @(posedge clk25MHz) begin
        if (!reset_n) begin
            r_rr_m3 <= '0;
        end else begin
            for (int k = 0; k < NUM_T; k++)
                if (w_tack[k] && w_gnt_id[k] != MID_M1)
                    r_rr_m3[k] <= (w_gnt_id[k] == MID_M2);
        end
    end
`endif

    for (genvar k = 0; k < NUM_T; k++) begin : g_tag
        bus_tag_fifo #(.DEPTH(TAG_DEPTH)) u_fifo (
            .clk25MHz (clk25MHz),
            .reset_n  (reset_n),
            .i_push   (w_push[k]),
            .i_pop    (w_pop[k]),
            .i_id     (w_gnt_id[k]),
            .o_full   (w_full[k]),
            .o_empty  (w_empty[k]),
            .o_head   (w_head[k])
        );
    end

endmodule

// File: tb/tb_bus_ctrl_3m2t.sv
// Directed bench for bus_ctrl_3m2t: a per-cycle vector table plus
// hand-written sequences for tag-FIFO full, cross-target ordering,
// reset with reads in flight and m2/m3 arbitration.
module tb_bus_ctrl_3m2t;
    logic clk25MHz;
    logic reset_n;

    bus_ctrl_3m2t_if m1_if ();
    bus_ctrl_3m2t_if m2_if ();
    bus_ctrl_3m2t_if m3_if ();
    bus_ctrl_3m2t_if t1_if ();
    bus_ctrl_3m2t_if t2_if ();

    bus_ctrl_3m2t #(.TAG_DEPTH(4), .T2_BASE(8'hFF)) dut (
        .clk25MHz (clk25MHz),
        .reset_n  (reset_n),
        .m1       (m1_if),
        .m2       (m2_if),
        .m3       (m3_if),
        .t1       (t1_if),
        .t2       (t2_if)
    );

    initial clk25MHz = 1'b0;
    always #20 clk25MHz = ~clk25MHz;

    localparam logic [33:0] W1 = 34'h2_0000_0000;

    typedef struct {
        logic [69:0] m1, m2, m3;
        logic [33:0] r1, r2;
        logic [33:0] e1, e2, e3;
        logic [69:0] x1, x2;
    } vec_t;

    vec_t tbl [15];
    int   n_pass = 0;
    int   n_tot  = 0;

    function automatic logic [69:0] RD(input logic [31:0] a);
        return {a, 1'b1, 1'b0, 32'h0, 4'hF};
    endfunction
    function automatic logic [69:0] WR(input logic [31:0] a, input logic [31:0] d);
        return {a, 1'b0, 1'b1, d, 4'hF};
    endfunction
    function automatic logic [33:0] RS(input logic w, input logic v, input logic [31:0] d);
        return {w, v, d};
    endfunction

    task automatic chk(input string nm, input logic [69:0] act, input logic [69:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    // One bus cycle: drive, settle, compare, advance past the next edge
    task automatic run(input string tag,
                       input logic [69:0] m1, input logic [69:0] m2, input logic [69:0] m3,
                       input logic [33:0] r1, input logic [33:0] r2,
                       input logic [33:0] e1, input logic [33:0] e2, input logic [33:0] e3,
                       input logic [69:0] x1, input logic [69:0] x2);
        m1_if.req = m1;
        m2_if.req = m2;
        m3_if.req = m3;
        t1_if.res = r1;
        t2_if.res = r2;
        #10;
        chk({tag, " m1_res"}, 70'(m1_if.res), 70'(e1));
        chk({tag, " m2_res"}, 70'(m2_if.res), 70'(e2));
        chk({tag, " m3_res"}, 70'(m3_if.res), 70'(e3));
        chk({tag, " t1_req"}, t1_if.req, x1);
        chk({tag, " t2_req"}, t2_if.req, x2);
        @(posedge clk25MHz);
        #1;
    endtask

    initial begin
        logic sel3;
        logic [69:0] w2, w3;

        // order: m1, m2, m3, r1, r2, e1, e2, e3, x1, x2
        // single read by m3 returning two cycles later; data masked without rd_valid
        tbl[0]  = '{'0, '0, RD(32'h4000_0010), '0, '0, '0, '0, '0, RD(32'h4000_0010), '0};
        tbl[1]  = '{'0, '0, '0, {1'b1, 1'b0, 32'hFFFF_FFFF}, '0, '0, '0, '0, '0, '0};
        tbl[2]  = '{'0, '0, '0, RS(0, 1, 32'h1234_5678), '0, '0, '0, RS(0, 1, 32'h1234_5678), '0, '0};
        // three simultaneous reads to t1: priority order, in-order return
        tbl[3]  = '{RD(32'h4000_0100), RD(32'h4000_0200), RD(32'h4000_0300), '0, '0,
                    '0, W1, W1, RD(32'h4000_0100), '0};
        tbl[4]  = '{'0, RD(32'h4000_0200), RD(32'h4000_0300), '0, '0,
                    '0, '0, W1, RD(32'h4000_0200), '0};
        tbl[5]  = '{'0, '0, RD(32'h4000_0300), RS(0, 1, 32'hAAAA_0001), '0,
                    RS(0, 1, 32'hAAAA_0001), '0, '0, RD(32'h4000_0300), '0};
        tbl[6]  = '{'0, '0, '0, RS(0, 1, 32'hBBBB_0002), '0, '0, RS(0, 1, 32'hBBBB_0002), '0, '0, '0};
        tbl[7]  = '{'0, '0, '0, RS(0, 1, 32'hCCCC_0003), '0, '0, '0, RS(0, 1, 32'hCCCC_0003), '0, '0};
        tbl[8]  = '{'0, '0, '0, RS(0, 1, 32'hDEAD_BEEF), '0, '0, '0, '0, '0, '0};
        // both targets granted at once; writes get no response
        tbl[9]  = '{RD(32'h4000_0000), WR(32'hFF00_0000, 32'h5555_AAAA), '0, '0, '0,
                    '0, '0, '0, RD(32'h4000_0000), WR(32'hFF00_0000, 32'h5555_AAAA)};
        tbl[10] = '{'0, '0, '0, RS(0, 1, 32'h0000_1111), '0, RS(0, 1, 32'h0000_1111), '0, '0, '0, '0};
        tbl[11] = '{'0, WR(32'hFF00_0004, 32'h1), '0, '0, W1, '0, W1, '0, '0, WR(32'hFF00_0004, 32'h1)};
        tbl[12] = '{'0, WR(32'hFF00_0004, 32'h1), '0, '0, '0, '0, '0, '0, '0, WR(32'hFF00_0004, 32'h1)};
        tbl[13] = '{WR(32'hFF00_0008, 32'h2), WR(32'hFF00_000C, 32'h3), '0, '0, '0,
                    '0, W1, '0, '0, WR(32'hFF00_0008, 32'h2)};
        tbl[14] = '{'0, WR(32'hFF00_000C, 32'h3), '0, '0, '0, '0, '0, '0, '0, WR(32'hFF00_000C, 32'h3)};

        reset_n = 1'b0;
        m1_if.req = '0; m2_if.req = '0; m3_if.req = '0;
        t1_if.res = '0; t2_if.res = '0;
        @(posedge clk25MHz);
        #1;

        // reset state: everyone stalled, no request forwarded
        for (int i = 0; i < 2; i++)
            run($sformatf("rst%0d", i), RD(32'h4000_0000), '0, WR(32'hFF00_0000, 32'h1), '0, '0,
                W1, W1, W1, '0, '0);
        reset_n = 1'b1;

        for (int i = 0; i < 15; i++)
            run($sformatf("vec%0d", i), tbl[i].m1, tbl[i].m2, tbl[i].m3, tbl[i].r1, tbl[i].r2,
                tbl[i].e1, tbl[i].e2, tbl[i].e3, tbl[i].x1, tbl[i].x2);

        // tag FIFO fills after 4 reads; 5th accepted after first return, with push+pop
        for (int i = 0; i < 4; i++)
            run($sformatf("full_iss%0d", i), '0, '0, RD(32'h4000_1000 + 32'(i * 4)), '0, '0,
                '0, '0, '0, RD(32'h4000_1000 + 32'(i * 4)), '0);
        for (int i = 0; i < 2; i++)
            run($sformatf("full_stall%0d", i), '0, '0, RD(32'h4000_2000), '0, '0,
                '0, '0, W1, '0, '0);
        run("full_ret0", '0, '0, RD(32'h4000_2000), RS(0, 1, 32'h1000_0000), '0,
            '0, '0, RS(1, 1, 32'h1000_0000), '0, '0);
        run("full_pushpop", '0, '0, RD(32'h4000_2000), RS(0, 1, 32'h1000_0001), '0,
            '0, '0, RS(0, 1, 32'h1000_0001), RD(32'h4000_2000), '0);
        run("full_ret2", '0, '0, '0, RS(0, 1, 32'h1000_0002), '0, '0, '0, RS(0, 1, 32'h1000_0002), '0, '0);
        run("full_ret3", '0, '0, '0, RS(0, 1, 32'h1000_0003), '0, '0, '0, RS(0, 1, 32'h1000_0003), '0, '0);
        run("full_ret4", '0, '0, '0, RS(0, 1, 32'h2000_0000), '0, '0, '0, RS(0, 1, 32'h2000_0000), '0, '0);
        run("full_empty", '0, '0, '0, RS(0, 1, 32'hDEAD_BEEF), '0, '0, '0, '0, '0, '0);

        // m2 must wait for its t1 read before reading t2
        run("xt_iss", '0, RD(32'h4000_3000), '0, '0, '0, '0, '0, '0, RD(32'h4000_3000), '0);
        for (int i = 0; i < 2; i++)
            run($sformatf("xt_block%0d", i), '0, RD(32'hFF00_0001), '0, '0, '0, '0, W1, '0, '0, '0);
        run("xt_ret", '0, RD(32'hFF00_0001), '0, RS(0, 1, 32'h3333_0000), '0,
            '0, RS(1, 1, 32'h3333_0000), '0, '0, '0);
        run("xt_acc", '0, RD(32'hFF00_0001), '0, '0, '0, '0, '0, '0, '0, RD(32'hFF00_0001));
        run("xt_ret2", '0, '0, '0, '0, RS(0, 1, 32'h4444_0000), '0, RS(0, 1, 32'h4444_0000), '0, '0, '0);

        // reset with two reads in flight: returns after reset are dropped
        run("rf_iss0", RD(32'h4000_4000), '0, '0, '0, '0, '0, '0, '0, RD(32'h4000_4000), '0);
        run("rf_iss1", RD(32'h4000_4004), '0, '0, '0, '0, '0, '0, '0, RD(32'h4000_4004), '0);
        reset_n = 1'b0;
        for (int i = 0; i < 2; i++)
            run($sformatf("rf_rst%0d", i), '0, RD(32'h4000_5000), RD(32'hFF00_0020),
                RS(0, 1, 32'h5555_0000), '0, W1, W1, W1, '0, '0);
        reset_n = 1'b1;
        run("rf_drop", '0, '0, '0, RS(0, 1, 32'h6666_0000), '0, '0, '0, '0, '0, '0);
        run("rf_cnt_clr", RD(32'hFF00_0010), '0, '0, '0, '0, '0, '0, '0, '0, RD(32'hFF00_0010));
        run("rf_ret", '0, '0, '0, '0, RS(0, 1, 32'h7777_0000), RS(0, 1, 32'h7777_0000), '0, '0, '0, '0);

        // m2 and m3 writing t1 every cycle
        for (int i = 0; i < 4; i++) begin
`ifdef BUS_CTRL_RR_EN
            sel3 = (i % 2) == 1;
`else
            sel3 = 1'b0;
`endif
            w2 = WR(32'h4000_6000, 32'(i));
            w3 = WR(32'h4000_6100, 32'(i + 16));
            run($sformatf("arb%0d", i), '0, w2, w3, '0, '0,
                '0, sel3 ? W1 : 34'h0, sel3 ? 34'h0 : W1, sel3 ? w3 : w2, '0);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
